// File: rtl/mc_cpu_pkg.sv
// Shared encodings for the multi-cycle CPU control unit: FSM states, opcodes,
// ALU operations, mux select values and the decoded-instruction bundle.
package mc_cpu_pkg;

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EXE_AL = 4'd2,
    S_EXE_BR = 4'd3,
    S_EXE_LS = 4'd4,
    S_MEM    = 4'd5,
    S_WB_AL  = 4'd6,
    S_WB_LD  = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010001;
  localparam logic [5:0] OP_ANDI  = 6'b010000;
  localparam logic [5:0] OP_OR    = 6'b010011;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLTI  = 6'b100110;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_BLTZ  = 6'b110110;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_SLL = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_SLT = 3'd5;

  localparam logic [1:0] DST_R31 = 2'b00;
  localparam logic [1:0] DST_RT  = 2'b01;
  localparam logic [1:0] DST_RD  = 2'b10;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JR  = 2'b10;
  localparam logic [1:0] PC_J   = 2'b11;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       src_a;
    logic       src_b;
    logic       ext_sel;
    logic [1:0] reg_dst;
  } dec_t;

endpackage

// File: rtl/mc_cpu_decode.sv
// Opcode -> ALU op / operand selects / extension / destination, plus illegal flag.
// Purely combinational, zero latency; no handshake.
module mc_cpu_decode
  import mc_cpu_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] op_code,
  output dec_t            dec,
  output logic            illegal
);

  always_comb begin
    dec     = '0;
    illegal = 1'b0;
    case (op_code)
      OP_ADD:   begin dec.alu_op = ALU_ADD; dec.reg_dst = DST_RD; end
      OP_SUB:   begin dec.alu_op = ALU_SUB; dec.reg_dst = DST_RD; end
      OP_ADDIU: begin dec.alu_op = ALU_ADD; dec.src_b = 1'b1; dec.ext_sel = 1'b1; dec.reg_dst = DST_RT; end
      OP_AND:   begin dec.alu_op = ALU_AND; dec.reg_dst = DST_RD; end
      OP_ANDI:  begin dec.alu_op = ALU_AND; dec.src_b = 1'b1; dec.reg_dst = DST_RT; end
      OP_OR:    begin dec.alu_op = ALU_OR;  dec.reg_dst = DST_RD; end
      OP_ORI:   begin dec.alu_op = ALU_OR;  dec.src_b = 1'b1; dec.reg_dst = DST_RT; end
      // Shift amount comes from the sa field on port A, value from rt on port B.
      OP_SLL:   begin dec.alu_op = ALU_SLL; dec.src_a = 1'b1; dec.reg_dst = DST_RD; end
      OP_SLTI:  begin dec.alu_op = ALU_SLT; dec.src_b = 1'b1; dec.ext_sel = 1'b1; dec.reg_dst = DST_RT; end
      OP_SW:    begin dec.alu_op = ALU_ADD; dec.src_b = 1'b1; dec.ext_sel = 1'b1; end
      OP_LW:    begin dec.alu_op = ALU_ADD; dec.src_b = 1'b1; dec.ext_sel = 1'b1; dec.reg_dst = DST_RT; end
      OP_BEQ, OP_BNE, OP_BLTZ: begin dec.alu_op = ALU_SUB; dec.ext_sel = 1'b1; end
      OP_J, OP_JR, OP_JAL, OP_HALT: ;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_cpu_ctrl.sv
// Multi-cycle IF/ID/EXE/MEM/WB control FSM with retired-instruction counter.
// 2-5 cycles per instruction; each ready-low cycle on an open memory request adds one.
module mc_cpu_ctrl
  import mc_cpu_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int ALUOP_W  = 3,
  parameter int RETIRE_W = 32
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [OP_W-1:0]     Op_code,
  input  logic                zero,
  input  logic                sign,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                dmem_rd,
  output logic                dmem_wr,
  output logic                PCWre,
  output logic                IRWre,
  output logic                RegWre,
  output logic [1:0]          RegDst,
  output logic                WrRegDSrc,
  output logic                ALUSrcA,
  output logic                ALUSrcB,
  output logic                DBDataSrc,
  output logic                ExtSel,
  output logic [ALUOP_W-1:0]  ALUopcode,
  output logic [1:0]          PCSrc,
  output logic [3:0]          state,
  output logic                halted,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired
);

  state_t cur_st, nxt_st;
  dec_t   dec;
  logic   dec_illegal;
  logic   set_illegal;
  logic   is_lw;
  logic   br_taken;

  mc_cpu_decode #(.OP_W(OP_W)) u_decode (
    .op_code (Op_code),
    .dec     (dec),
    .illegal (dec_illegal)
  );

  assign state = cur_st;
  assign is_lw = (Op_code == OP_LW);

  always_comb begin
    br_taken = 1'b0;
    case (Op_code)
      OP_BEQ:  br_taken = zero;
      OP_BNE:  br_taken = ~zero;
      OP_BLTZ: br_taken = sign;
      default: br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      cur_st  <= S_IF;
      retired <= '0;
      illegal <= 1'b0;
    end else begin
      cur_st <= nxt_st;
      if (set_illegal)
        illegal <= 1'b1;
      if (PCWre && (retired != '1))
        retired <= retired + RETIRE_W'(1);
    end
  end

  always_comb begin
    nxt_st      = cur_st;
    set_illegal = 1'b0;
    imem_req    = 1'b0;
    dmem_rd     = 1'b0;
    dmem_wr     = 1'b0;
    PCWre       = 1'b0;
    IRWre       = 1'b0;
    RegWre      = 1'b0;
    RegDst      = DST_R31;
    WrRegDSrc   = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 1'b0;
    DBDataSrc   = 1'b0;
    ExtSel      = 1'b0;
    ALUopcode   = '0;
    PCSrc       = PC_SEQ;
    halted      = 1'b0;
    // Reset silences every output so an in-flight memory access is dropped.
    if (!Reset) begin
      case (cur_st)
        S_IF: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            IRWre  = 1'b1;
            nxt_st = S_ID;
          end
        end
        S_ID: begin
          case (Op_code)
            OP_J:    begin PCWre = 1'b1; PCSrc = PC_J;  nxt_st = S_IF; end
            OP_JR:   begin PCWre = 1'b1; PCSrc = PC_JR; nxt_st = S_IF; end
            OP_JAL:  begin
              PCWre = 1'b1; PCSrc = PC_J; RegWre = 1'b1; RegDst = DST_R31;
              WrRegDSrc = 1'b0; nxt_st = S_IF;
            end
            OP_HALT: nxt_st = S_HALT;
            OP_BEQ, OP_BNE, OP_BLTZ: nxt_st = S_EXE_BR;
            OP_LW, OP_SW:            nxt_st = S_EXE_LS;
            default: begin
              if (dec_illegal) begin
                set_illegal = 1'b1;
                nxt_st      = S_HALT;
              end else begin
                nxt_st = S_EXE_AL;
              end
            end
          endcase
        end
        // ALU selects are held through write-back since DB is the live ALU output.
        S_EXE_AL, S_WB_AL: begin
          ALUopcode = ALUOP_W'(dec.alu_op);
          ALUSrcA   = dec.src_a;
          ALUSrcB   = dec.src_b;
          ExtSel    = dec.ext_sel;
          RegDst    = dec.reg_dst;
          if (cur_st == S_WB_AL) begin
            RegWre    = 1'b1;
            WrRegDSrc = 1'b1;
            PCWre     = 1'b1;
            nxt_st    = S_IF;
          end else begin
            nxt_st = S_WB_AL;
          end
        end
        S_EXE_BR: begin
          ALUopcode = ALUOP_W'(ALU_SUB);
          ExtSel    = 1'b1;
          PCWre     = 1'b1;
          PCSrc     = br_taken ? PC_BR : PC_SEQ;
          nxt_st    = S_IF;
        end
        S_EXE_LS, S_MEM, S_WB_LD: begin
          ALUopcode = ALUOP_W'(ALU_ADD);
          ALUSrcB   = 1'b1;
          ExtSel    = 1'b1;
          if (cur_st == S_EXE_LS) begin
            nxt_st = S_MEM;
          end else if (cur_st == S_MEM) begin
            dmem_rd = is_lw;
            dmem_wr = ~is_lw;
            if (dmem_ready) begin
              if (is_lw) begin
                nxt_st = S_WB_LD;
              end else begin
                PCWre  = 1'b1;
                nxt_st = S_IF;
              end
            end
          end else begin
            RegWre    = 1'b1;
            RegDst    = DST_RT;
            DBDataSrc = 1'b1;
            WrRegDSrc = 1'b1;
            PCWre     = 1'b1;
            nxt_st    = S_IF;
          end
        end
        S_HALT:  halted = 1'b1;
        default: nxt_st = S_IF;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_cpu_ctrl.sv
// Directed per-cycle vector table plus hand-written reset/illegal/halt sequences.
module tb_mc_cpu_ctrl;

  localparam logic [5:0] O_ADD  = 6'b000000;
  localparam logic [5:0] O_ORI  = 6'b010010;
  localparam logic [5:0] O_SLL  = 6'b011000;
  localparam logic [5:0] O_SLTI = 6'b100110;
  localparam logic [5:0] O_SW   = 6'b110000;
  localparam logic [5:0] O_LW   = 6'b110001;
  localparam logic [5:0] O_BEQ  = 6'b110100;
  localparam logic [5:0] O_BNE  = 6'b110101;
  localparam logic [5:0] O_BLTZ = 6'b110110;
  localparam logic [5:0] O_J    = 6'b111000;
  localparam logic [5:0] O_JR   = 6'b111001;
  localparam logic [5:0] O_JAL  = 6'b111010;
  localparam logic [5:0] O_HALT = 6'b111111;
  localparam logic [5:0] O_ILL  = 6'b101010;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [5:0]  Op_code = '0;
  logic        zero = 1'b0, sign = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic        imem_req, dmem_rd, dmem_wr, PCWre, IRWre, RegWre;
  logic [1:0]  RegDst, PCSrc;
  logic        WrRegDSrc, ALUSrcA, ALUSrcB, DBDataSrc, ExtSel;
  logic [2:0]  ALUopcode;
  logic [3:0]  state;
  logic        halted, illegal;
  logic [31:0] retired;

  always #5 CLK = ~CLK;

  mc_cpu_ctrl dut (
    .CLK(CLK), .Reset(Reset), .Op_code(Op_code), .zero(zero), .sign(sign),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
    .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .RegDst(RegDst),
    .WrRegDSrc(WrRegDSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .DBDataSrc(DBDataSrc), .ExtSel(ExtSel), .ALUopcode(ALUopcode),
    .PCSrc(PCSrc), .state(state), .halted(halted), .illegal(illegal),
    .retired(retired)
  );

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        z, s, ir, dr;
    logic [3:0]  st;
    logic [2:0]  req;   // imem_req, dmem_rd, dmem_wr
    logic [2:0]  en;    // PCWre, IRWre, RegWre
    logic [6:0]  sel;   // RegDst[1:0], WrRegDSrc, ALUSrcA, ALUSrcB, DBDataSrc, ExtSel
    logic [2:0]  alu;
    logic [1:0]  pcs;
    logic        hlt, ill;
    logic [31:0] ret;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;
  int   n;

  task automatic v(input logic rst, input logic [5:0] op, input logic z, s, ir, dr,
                   input logic [3:0] st, input logic [2:0] req, en, input logic [6:0] sel,
                   input logic [2:0] alu, input logic [1:0] pcs, input logic hlt, ill,
                   input logic [31:0] ret);
    vec_t t;
    t.rst = rst; t.op = op; t.z = z; t.s = s; t.ir = ir; t.dr = dr;
    t.st = st; t.req = req; t.en = en; t.sel = sel; t.alu = alu; t.pcs = pcs;
    t.hlt = hlt; t.ill = ill; t.ret = ret;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic rst, input logic [5:0] op, input logic z, s, ir, dr);
    @(negedge CLK);
    Reset = rst; Op_code = op; zero = z; sign = s; imem_ready = ir; dmem_ready = dr;
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  function automatic logic [55:0] act();
    return {state, imem_req, dmem_rd, dmem_wr, PCWre, IRWre, RegWre,
            RegDst, WrRegDSrc, ALUSrcA, ALUSrcB, DBDataSrc, ExtSel,
            ALUopcode, PCSrc, halted, illegal, retired};
  endfunction

  initial begin
    // reset held two cycles
    v(1, O_ADD, 0,0,1,1, 4'd0, 3'b000, 3'b000, 7'b0000000, 3'd0, 2'b00, 0,0, 0);
    v(1, O_ADD, 0,0,1,1, 4'd0, 3'b000, 3'b000, 7'b0000000, 3'd0, 2'b00, 0,0, 0);
    // add, zero-wait
    v(0, O_ADD, 0,0,1,1, 4'd0, 3'b100, 3'b010, 7'b0000000, 3'd0, 2'b00, 0,0, 0);
    v(0, O_ADD, 0,0,1,1, 4'd1, 3'b000, 3'b000, 7'b0000000, 3'd0, 2'b00, 0,0, 0);
    v(0, O_ADD, 0,0,1,1, 4'd2, 3'b000, 3'b000, 7'b1000000, 3'd0, 2'b00, 0,0, 0);
    v(0, O_ADD, 0,0,1,1, 4'd6, 3'b000, 3'b101, 7'b1010000, 3'd0, 2'b00, 0,0, 0);
    // lw with three dmem wait cycles
    v(0, O_LW, 0,0,1,1, 4'd0, 3'b100, 3'b010, 7'b0000000, 3'd0, 2'b00, 0,0, 1);
    v(0, O_LW, 0,0,1,1, 4'd1, 3'b000, 3'b000, 7'b0000000, 3'd0, 2'b00, 0,0, 1);
    v(0, O_LW, 0,0,1,1, 4'd4, 3'b000, 3'b000, 7'b0000101, 3'd0, 2'b00, 0,0, 1);
    for (int k = 0; k < 3; k++)
      v(0, O_LW, 0,0,1,0, 4'd5, 3'b010, 3'b000, 7'b0000101, 3'd0, 2'b00, 0,0, 1);
    v(0, O_LW, 0,0,1,1, 4'd5, 3'b010, 3'b000, 7'b0000101, 3'd0, 2'b00, 0,0, 1);
    v(0, O_LW, 0,0,1,1, 4'd7, 3'b000, 3'b101, 7'b0110111, 3'd0, 2'b00, 0,0, 1);
    // beq taken, bne not taken, bltz taken
    v(0, O_BEQ, 1,0,1,1, 4'd0, 3'b100, 3'b010, 7'b0000000, 3'd0, 2'b00, 0,0, 2);
    v(0, O_BEQ, 1,0,1,1, 4'd1, 3'b000, 3'b000, 7'b0000000, 3'd0, 2'b00, 0,0, 2);
    v(0, O_BEQ, 1,0,1,1, 4'd3, 3'b000, 3'b100, 7'b0000001, 3'd1, 2'b01, 0,0, 2);
    v(0, O_BNE, 1,0,1,1, 4'd0, 3'b100, 3'b010, 7'b0000000, 3'd0, 2'b00, 0,0, 3);
    v(0, O_BNE, 1,0,1,1, 4'd1, 3'b000, 3'b000, 7'b0000000, 3'd0, 2'b00, 0,0, 3);
    v(0, O_BNE, 1,0,1,1, 4'd3, 3'b000, 3'b100, 7'b0000001, 3'd1, 2'b00, 0,0, 3);
    v(0, O_BLTZ, 0,1,1,1, 4'd0, 3'b100, 3'b010, 7'b0000000, 3'd0, 2'b00, 0,0, 4);
    v(0, O_BLTZ, 0,1,1,1, 4'd1, 3'b000, 3'b000, 7'b0000000, 3'd0, 2'b00, 0,0, 4);
    v(0, O_BLTZ, 0,1,1,1, 4'd3, 3'b000, 3'b100, 7'b0000001, 3'd1, 2'b01, 0,0, 4);
    // jal with one imem wait, then j and jr
    v(0, O_JAL, 0,0,0,1, 4'd0, 3'b100, 3'b000, 7'b0000000, 3'd0, 2'b00, 0,0, 5);
    v(0, O_JAL, 0,0,1,1, 4'd0, 3'b100, 3'b010, 7'b0000000, 3'd0, 2'b00, 0,0, 5);
    v(0, O_JAL, 0,0,1,1, 4'd1, 3'b000, 3'b101, 7'b0000000, 3'd0, 2'b11, 0,0, 5);
    v(0, O_J,   0,0,1,1, 4'd0, 3'b100, 3'b010, 7'b0000000, 3'd0, 2'b00, 0,0, 6);
    v(0, O_J,   0,0,1,1, 4'd1, 3'b000, 3'b100, 7'b0000000, 3'd0, 2'b11, 0,0, 6);
    v(0, O_JR,  0,0,1,1, 4'd0, 3'b100, 3'b010, 7'b0000000, 3'd0, 2'b00, 0,0, 7);
    v(0, O_JR,  0,0,1,1, 4'd1, 3'b000, 3'b100, 7'b0000000, 3'd0, 2'b10, 0,0, 7);
    // immediate / shift ALU ops
    v(0, O_ORI, 0,0,1,1, 4'd0, 3'b100, 3'b010, 7'b0000000, 3'd0, 2'b00, 0,0, 8);
    v(0, O_ORI, 0,0,1,1, 4'd1, 3'b000, 3'b000, 7'b0000000, 3'd0, 2'b00, 0,0, 8);
    v(0, O_ORI, 0,0,1,1, 4'd2, 3'b000, 3'b000, 7'b0100100, 3'd3, 2'b00, 0,0, 8);
    v(0, O_ORI, 0,0,1,1, 4'd6, 3'b000, 3'b101, 7'b0110100, 3'd3, 2'b00, 0,0, 8);
    v(0, O_SLL, 0,0,1,1, 4'd0, 3'b100, 3'b010, 7'b0000000, 3'd0, 2'b00, 0,0, 9);
    v(0, O_SLL, 0,0,1,1, 4'd1, 3'b000, 3'b000, 7'b0000000, 3'd0, 2'b00, 0,0, 9);
    v(0, O_SLL, 0,0,1,1, 4'd2, 3'b000, 3'b000, 7'b1001000, 3'd2, 2'b00, 0,0, 9);
    v(0, O_SLL, 0,0,1,1, 4'd6, 3'b000, 3'b101, 7'b1011000, 3'd2, 2'b00, 0,0, 9);
    v(0, O_SLTI, 0,0,1,1, 4'd0, 3'b100, 3'b010, 7'b0000000, 3'd0, 2'b00, 0,0, 10);
    v(0, O_SLTI, 0,0,1,1, 4'd1, 3'b000, 3'b000, 7'b0000000, 3'd0, 2'b00, 0,0, 10);
    v(0, O_SLTI, 0,0,1,1, 4'd2, 3'b000, 3'b000, 7'b0100101, 3'd5, 2'b00, 0,0, 10);
    v(0, O_SLTI, 0,0,1,1, 4'd6, 3'b000, 3'b101, 7'b0110101, 3'd5, 2'b00, 0,0, 10);

    foreach (vecs[i]) begin
      vec_t t;
      t = vecs[i];
      drive(t.rst, t.op, t.z, t.s, t.ir, t.dr);
      chk($sformatf("vec%0d", i), {8'd0, act()},
          {8'd0, t.st, t.req, t.en, t.sel, t.alu, t.pcs, t.hlt, t.ill, t.ret});
    end

    // sw aborted by reset during a data-memory wait
    drive(0, O_SW, 0,0,1,0);
    chk("sw_if", {retired, state, imem_req, IRWre}, {32'd11, 4'd0, 1'b1, 1'b1});
    drive(0, O_SW, 0,0,1,0);
    drive(0, O_SW, 0,0,1,0);
    chk("sw_exe", {state, ALUopcode, ALUSrcB, ExtSel}, {4'd4, 3'd0, 1'b1, 1'b1});
    drive(0, O_SW, 0,0,1,0);
    chk("sw_mem", {state, dmem_rd, dmem_wr, PCWre}, {4'd5, 1'b0, 1'b1, 1'b0});
    drive(0, O_SW, 0,0,1,0);
    chk("sw_mem_hold", {state, dmem_rd, dmem_wr, PCWre}, {4'd5, 1'b0, 1'b1, 1'b0});
    drive(1, O_SW, 0,0,1,1);
    chk("sw_rst_cycle", {dmem_wr, dmem_rd, PCWre, imem_req}, 4'b0000);
    drive(0, O_SW, 0,0,1,1);
    chk("after_rst", {state, illegal, imem_req, retired}, {4'd0, 1'b0, 1'b1, 32'd0});

    // zero-wait sw: four cycles, final cycle writes and retires
    n = 1;
    while (PCWre !== 1'b1 && n < 10) begin
      drive(0, O_SW, 0,0,1,1);
      n++;
    end
    chk("sw_cycles", n, 4);
    chk("sw_final", {state, dmem_wr, PCWre}, {4'd5, 1'b1, 1'b1});

    // undefined opcode halts with illegal set and no more requests
    drive(0, O_ILL, 0,0,1,1);
    chk("ill_if", {state, retired}, {4'd0, 32'd1});
    drive(0, O_ILL, 0,0,1,1);
    chk("ill_id", {state, illegal, PCWre}, {4'd1, 1'b0, 1'b0});
    for (int k = 0; k < 3; k++) begin
      drive(0, O_ILL, 0,0,1,1);
      chk($sformatf("ill_halt%0d", k),
          {state, halted, illegal, imem_req, dmem_rd, dmem_wr, PCWre, IRWre, RegWre, retired},
          {4'd8, 1'b1, 1'b1, 6'b000000, 32'd1});
    end
    drive(1, O_HALT, 0,0,1,1);
    chk("halt_rst_cycle", {imem_req, PCWre}, 2'b00);

    // halt opcode: absorbing, not illegal, not retired
    drive(0, O_HALT, 0,0,1,1);
    chk("halt_op_if", {state, halted, illegal, retired}, {4'd0, 1'b0, 1'b0, 32'd0});
    drive(0, O_HALT, 0,0,1,1);
    drive(0, O_HALT, 0,0,1,1);
    chk("halt_op", {state, halted, illegal, imem_req, retired}, {4'd8, 1'b1, 1'b0, 1'b0, 32'd0});
    drive(0, O_ADD, 0,0,1,1);
    chk("halt_stays", {state, halted, imem_req, PCWre}, {4'd8, 1'b1, 1'b0, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_cpu_ctrl.md
Name: mc_cpu_ctrl

Overview:
- Multi-cycle control unit for the next-generation CPU core, replacing the single-cycle combinational decoder.
- Sequences each instruction through IF/ID/EXE/MEM/WB with a request/ready handshake to instruction and data memory, so memories may take any number of wait cycles.
- Drives all datapath selects and write enables, gates PC/IR updates, and counts retired instructions.
- Sits between the instruction register opcode and the existing PC, RegFile, ALU32, Data_Memory and mux datapath.

Parameters:
- OP_W, 6, opcode width.
- ALUOP_W, 3, ALU operation select width.
- RETIRE_W, 32, width of the retired-instruction counter (saturating).

Ports:
- CLK  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high reset
- Op_code  in  OP_W  opcode of current IR (valid from ID onward)
- zero  in  1  ALU zero flag
- sign  in  1  ALU sign flag
- imem_ready  in  1  instruction memory read complete this cycle
- dmem_ready  in  1  data memory access complete this cycle
- imem_req  out  1  instruction fetch request
- dmem_rd  out  1  data memory read request
- dmem_wr  out  1  data memory write request
- PCWre  out  1  PC load enable
- IRWre  out  1  IR load enable
- RegWre  out  1  register file write enable
- RegDst  out  2  write reg: 00=$31, 01=rt, 10=rd
- WrRegDSrc  out  1  write data: 0=PC+4, 1=DB (ALU/mem)
- ALUSrcA  out  1  0=rs, 1=sa
- ALUSrcB  out  1  0=rt, 1=ext imm
- DBDataSrc  out  1  0=ALU result, 1=memory data
- ExtSel  out  1  0=zero-extend, 1=sign-extend
- ALUopcode  out  ALUOP_W  ALU operation
- PCSrc  out  2  00=PC+4, 01=branch target, 10=rs (jr), 11=jump target
- state  out  4  current FSM state (debug)
- halted  out  1  in S_HALT
- illegal  out  1  sticky, set on undefined opcode
- retired  out  RETIRE_W  instructions completed

Behaviour:
- Reset high at a clock edge: state<=S_IF, retired<=0, illegal<=0. While Reset is high, every control output is forced to 0, including imem_req. The first cycle after reset is S_IF with imem_req=1.
- All control outputs are combinational from (state, Op_code, zero, sign, ready). State, retired and illegal are registered.
- S_IF: imem_req=1. Hold until imem_ready. On imem_ready: IRWre=1 for exactly that cycle, then go to S_ID.
- S_ID: decode Op_code.
  - j: PCWre=1, PCSrc=11; go to S_IF.
  - jr: PCWre=1, PCSrc=10; go to S_IF.
  - jal: PCWre=1, PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0; go to S_IF.
  - halt: go to S_HALT.
  - Undefined opcode: set illegal, go to S_HALT.
  - beq/bne/bltz: go to S_EXE_BR.
  - lw/sw: go to S_EXE_LS.
  - Otherwise: go to S_EXE_AL.
- S_EXE_AL: ALU operation and selects per opcode; go to S_WB_AL.
- S_WB_AL: RegWre=1, WrRegDSrc=1, DBDataSrc=0, PCWre=1, PCSrc=00; go to S_IF.
- S_EXE_BR: ALUopcode=SUB, ALUSrcB=0, PCWre=1.
  - PCSrc=01 if taken, else 00. Taken: beq when zero=1; bne when zero=0; bltz when sign=1.
  - Go to S_IF.
- S_EXE_LS: ALUopcode=ADD, ALUSrcB=1, ExtSel=1; go to S_MEM.
- S_MEM: dmem_rd (lw) or dmem_wr (sw) held high until dmem_ready.
  - sw: on dmem_ready, PCWre=1; go to S_IF.
  - lw: on dmem_ready, go to S_WB_LD.
- S_WB_LD: RegWre=1, RegDst=01, DBDataSrc=1, WrRegDSrc=1, PCWre=1; go to S_IF.
- S_HALT: absorbing; all enables 0, halted=1. Exit only by Reset.
- PCWre is asserted exactly once per instruction, in its final cycle.
- retired increments on every PCWre cycle and saturates at all-ones. halt is not counted.
- Zero-wait cycle counts:
  - ALU ops: 4
  - lw: 5
  - sw: 4
  - branch: 3
  - j/jr/jal: 2
  - Each ready-low cycle adds one cycle.
- Request signals stay asserted and stable while waiting. A ready seen outside a request is ignored.
- Reset during a memory wait aborts the access; the request is low in the reset cycle.
- ExtSel: 1 for addiu, slti, lw, sw, branches; 0 for andi, ori.

Decomposition:
- Package mc_cpu_pkg holds:
  - State encodings: S_IF, S_ID, S_EXE_AL, S_EXE_BR, S_EXE_LS, S_MEM, S_WB_AL, S_WB_LD, S_HALT.
  - Opcode constants: add 000000, sub 000001, addiu 000010, and 010001, andi 010000, or 010011, ori 010010, sll 011000, slti 100110, sw 110000, lw 110001, beq 110100, bne 110101, bltz 110110, j 111000, jr 111001, jal 111010, halt 111111.
  - ALUopcode constants: ADD, SUB, SLL, OR, AND, SLT.
- One sub-module, mc_cpu_decode: combinational map of opcode to ALUopcode/ALUSrcA/ALUSrcB/ExtSel/RegDst plus an illegal flag. The FSM stays in mc_cpu_ctrl.

Test Plan:
- Reset held 2 cycles, then add with both readies tied 1 -> states IF,ID,EXE_AL,WB_AL; RegWre=1 and PCWre=1 only in cycle 4; RegDst=10; retired=1.
- lw with dmem_ready low 3 cycles -> dmem_rd high 4 consecutive cycles; S_WB_LD has DBDataSrc=1, RegDst=01; 8 cycles total; retired increments once.
- beq with zero=1, then bne with zero=1 -> PCSrc=01 then PCSrc=00; each takes 3 cycles.
- jal -> in ID: PCWre=1, PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0; next state S_IF.
- Opcode 101010 -> illegal=1, halted=1, no further requests until Reset; retired unchanged.
- Reset asserted mid-S_MEM on sw -> dmem_wr=0 in reset cycle; after release state=S_IF, retired=0, illegal=0.
